ising_anneal_sequencer: RTL

- Trial scheduler for the coupled-oscillator Ising array. The host runs it through the OCL AXI-L write and read decode.
- Runs NUM_TRIALS anneal trials. Each trial: clear the array, run it for a programmed cycle count, sample the spins, capture them.
- Accumulates a per-spin "+1" histogram so the host can read the majority solution without polling every trial.
- Sits between the OCL slave logic and the Ising array's control/spin ports.

---
 rtl/ising_anneal_sequencer_if.sv | 21 ++
 rtl/ising_anneal_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ising_anneal_sequencer_if.sv
// Host register bus between the OCL slave logic and the anneal sequencer.
// Single-cycle write strobe and a registered read with one-cycle latency.
interface ising_anneal_sequencer_if;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_req, rd_addr,
        input  rd_valid, rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_req, rd_addr,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/ising_anneal_sequencer.sv
// Trial scheduler for the coupled-oscillator Ising array: clear, run, sample and
// capture per trial, accumulating a saturating per-spin "+1" histogram.
module ising_anneal_sequencer #(
    parameter int N            = 6,
    parameter int CNT_W        = 16,
    parameter int CLEAR_CYCLES = 4,
    parameter int SAMPLE_LAT   = 2
) (
    input  logic                        clk_main_a0,
    input  logic                        rst_main_n,
    ising_anneal_sequencer_if.slave     ocl,
    output logic                        core_clear,
    output logic                        core_run,
    output logic                        core_sample,
    input  logic [N-1:0]                core_spins,
    output logic                        busy,
    output logic                        done_irq
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_SAMPLE, S_WAIT, S_CAPTURE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        run_cycles_q, run_cycles_d;
    logic [CNT_W-1:0]   num_trials_q, num_trials_d;
    logic [CNT_W-1:0]   trials_done_q, trials_done_d;
    logic               done_q, done_d;
    logic               done_irq_q, done_irq_d;
    logic [N-1:0]       last_spins_q, last_spins_d;
    logic [CNT_W-1:0]   spin_count_q [N];
    logic [CNT_W-1:0]   spin_count_d [N];
    logic               core_clear_q, core_clear_d;
    logic               core_run_q, core_run_d;
    logic               core_sample_q, core_sample_d;
    logic               busy_q, busy_d;
    logic               rd_valid_q, rd_valid_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic wr_ctrl, start, abort, run_last;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        run_cycles_d  = run_cycles_q;
        num_trials_d  = num_trials_q;
        trials_done_d = trials_done_q;
        done_d        = done_q;
        done_irq_d    = 1'b0;
        last_spins_d  = last_spins_q;
        spin_count_d  = spin_count_q;

        wr_ctrl  = ocl.wr_en && (ocl.wr_addr == 8'h00);
        start    = wr_ctrl && ocl.wr_data[0];
        abort    = wr_ctrl && ocl.wr_data[1];
        // RUN_CYCLES of 0 still runs one cycle; compare against count-1 so 32'hFFFFFFFF never wraps.
        run_last = (run_cycles_q == '0) || (cnt_q == run_cycles_q - 32'd1);

        if (ocl.wr_en && !busy_q) begin
            if (ocl.wr_addr == 8'h04) run_cycles_d = ocl.wr_data;
            if (ocl.wr_addr == 8'h08) num_trials_d = ocl.wr_data[CNT_W-1:0];
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (num_trials_q != '0) begin
                        state_d       = S_CLEAR;
                        cnt_d         = '0;
                        trials_done_d = '0;
                        done_d        = 1'b0;
                        for (int unsigned i = 0; i < N; i++) spin_count_d[i] = '0;
                    end else begin
                        done_d     = 1'b1;
                        done_irq_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (cnt_q == 32'(CLEAR_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 32'd1;
            end
            S_RUN: begin
                if (run_last) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 32'd1;
            end
            S_SAMPLE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (cnt_q == 32'(SAMPLE_LAT - 1)) state_d = S_CAPTURE;
                else cnt_d = cnt_q + 32'd1;
            end
            S_CAPTURE: begin
                last_spins_d  = core_spins;
                trials_done_d = trials_done_q + CNT_W'(1);
                for (int unsigned i = 0; i < N; i++)
                    if (core_spins[i] && spin_count_q[i] != '1)
                        spin_count_d[i] = spin_count_q[i] + CNT_W'(1);
                if (trials_done_q + CNT_W'(1) == num_trials_q) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    done_irq_d = 1'b1;
                end else begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            done_d     = done_q;
            done_irq_d = 1'b0;
        end

        core_clear_d  = (state_d == S_IDLE) || (state_d == S_CLEAR);
        core_run_d    = (state_d == S_RUN) || (state_d == S_SAMPLE) || (state_d == S_WAIT);
        core_sample_d = (state_d == S_SAMPLE);
        busy_d        = (state_d != S_IDLE);

        rd_valid_d = ocl.rd_req;
        rd_data_d  = '0;
        if (ocl.rd_req) begin
            case (ocl.rd_addr)
                8'h04:   rd_data_d = run_cycles_q;
                8'h08:   rd_data_d = 32'(num_trials_q);
                8'h0C:   rd_data_d = (32'(trials_done_q) << 16) | {30'd0, done_q, busy_q};
                8'h10:   rd_data_d = 32'(last_spins_q);
                default: begin
                    for (int unsigned i = 0; i < N; i++)
                        if (ocl.rd_addr == 8'(8'h40 + 4 * i)) rd_data_d = 32'(spin_count_q[i]);
                end
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            run_cycles_q  <= '0;
            num_trials_q  <= '0;
            trials_done_q <= '0;
            done_q        <= 1'b0;
            done_irq_q    <= 1'b0;
            last_spins_q  <= '0;
            for (int unsigned i = 0; i < N; i++) spin_count_q[i] <= '0;
            core_clear_q  <= 1'b1;
            core_run_q    <= 1'b0;
            core_sample_q <= 1'b0;
            busy_q        <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            run_cycles_q  <= run_cycles_d;
            num_trials_q  <= num_trials_d;
            trials_done_q <= trials_done_d;
            done_q        <= done_d;
            done_irq_q    <= done_irq_d;
            last_spins_q  <= last_spins_d;
            spin_count_q  <= spin_count_d;
            core_clear_q  <= core_clear_d;
            core_run_q    <= core_run_d;
            core_sample_q <= core_sample_d;
            busy_q        <= busy_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign core_clear   = core_clear_q;
    assign core_run     = core_run_q;
    assign core_sample  = core_sample_q;
    assign busy         = busy_q;
    assign done_irq     = done_irq_q;
    assign ocl.rd_valid = rd_valid_q;
    assign ocl.rd_data  = rd_data_q;

endmodule
